// File: rtl/chan_invert_ctrl.sv
// chan_invert_ctrl: registered, parametrised channel conditioner.
// Each channel is synchronised, then either passed straight through (mask bit
// clear) or shaped by the runtime mode: pass, invert, blink against a
// prescaled phase, or toggle on every rising input edge.
module chan_invert_ctrl #(
  parameter int                WIDTH       = 8,
  parameter int                SYNC_STAGES = 2,
  parameter int                DIV_W       = 8,
  parameter logic [DIV_W-1:0]  DIV_RESET   = 8'hFF,
  parameter logic [WIDTH-1:0]  MASK_RESET  = 8'h0F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             tick
);

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INV    = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] mode_out;
  logic [WIDTH-1:0] dout_next;
  logic [DIV_W-1:0] cnt;
  logic             phase;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] mask_r;
  logic [DIV_W-1:0] div_r;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign s = din;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      // Synchroniser chain shifts every cycle, independent of ena, so the
      // conditioned view of din never goes stale while processing is frozen.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = s & ~prev;

  // Toggle state: a config write wipes it (and swallows any coincident edge);
  // otherwise masked channels flip on rising edges while in TOGGLE mode.
  always_comb begin
    t_next = t;
    if (cfg_we) begin
      t_next = '0;
    end else if (ena && (mode_r == MODE_TOGGLE)) begin
      t_next = t ^ (rise & mask_r);
    end
  end

  // Output selection under the current mode; unmasked channels bypass it.
  always_comb begin
    mode_out = s;
    case (mode_r)
      MODE_PASS:   mode_out = s;
      MODE_INV:    mode_out = ~s;
      MODE_BLINK:  mode_out = s ^ {WIDTH{phase}};
      MODE_TOGGLE: mode_out = t_next;
      default:     mode_out = s;
    endcase
    dout_next = (mode_out & mask_r) | (s & ~mask_r);
  end

  // Main state: config registers, prescaler, edge history and outputs.
  // Reset beats cfg_we, and cfg_we beats a coincident prescaler wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout   <= '0;
      tick   <= 1'b0;
      prev   <= '0;
      t      <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
      mode_r <= MODE_INV;
      mask_r <= MASK_RESET;
      div_r  <= DIV_RESET;
    end else begin
      t <= t_next;
      if (ena) begin
        prev <= s;
        dout <= dout_next;
      end
      if (cfg_we) begin
        mode_r <= cfg_mode;
        mask_r <= cfg_mask;
        div_r  <= cfg_div;
        cnt    <= '0;
        phase  <= 1'b0;
        tick   <= 1'b0;
      end else if (ena) begin
        if (cnt == div_r) begin
          cnt   <= '0;
          phase <= ~phase;
          tick  <= 1'b1;
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_invert_ctrl.sv
// tb_chan_invert_ctrl: drives the channel conditioner with directed scenarios
// and random traffic, comparing dout/tick against a behavioural model that
// keeps input history in a queue and evaluates each channel's rule directly.
module tb_chan_invert_ctrl;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ena = 1'b1;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_mode = 2'd0;
  logic [WIDTH-1:0] cfg_mask = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             tick;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [WIDTH-1:0] din_q[$];
  logic [WIDTH-1:0] m_dout, m_prev, m_t, m_mask;
  logic             m_tick, m_phase;
  logic [1:0]       m_mode;
  int               m_cnt, m_div;

  chan_invert_ctrl #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DIV_W(DIV_W),
    .DIV_RESET(8'hFF), .MASK_RESET(8'h0F)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .cfg_mask(cfg_mask), .cfg_div(cfg_div), .din(din), .dout(dout), .tick(tick)
  );

  always #5 clk = ~clk;

  // Model of one rising edge, evaluated from the per-channel rules.
  task automatic model_edge();
    logic [WIDTH-1:0] s, nt, nd;
    if (rst) begin
      din_q.delete();
      for (int k = 0; k < SYNC; k++) din_q.push_back('0);
      m_dout = '0; m_tick = 0; m_prev = '0; m_t = '0;
      m_cnt = 0; m_phase = 0; m_mode = 2'd1; m_mask = 8'h0F; m_div = 255;
    end else begin
      s = (SYNC == 0) ? din : din_q[0];
      if (SYNC != 0) begin
        din_q.push_back(din);
        void'(din_q.pop_front());
      end
      nd = m_dout;
      for (int i = 0; i < WIDTH; i++) begin
        if (cfg_we) nt[i] = 1'b0;
        else if (ena && m_mode == 2'd3 && m_mask[i] && s[i] && !m_prev[i]) nt[i] = ~m_t[i];
        else nt[i] = m_t[i];
        if (!m_mask[i]) nd[i] = s[i];
        else if (m_mode == 2'd0) nd[i] = s[i];
        else if (m_mode == 2'd1) nd[i] = ~s[i];
        else if (m_mode == 2'd2) nd[i] = s[i] ^ m_phase;
        else nd[i] = nt[i];
      end
      if (ena) begin
        m_dout = nd;
        m_prev = s;
      end
      m_t = nt;
      if (cfg_we) begin
        m_mode = cfg_mode; m_mask = cfg_mask; m_div = int'(cfg_div);
        m_cnt = 0; m_phase = 0; m_tick = 0;
      end else if (ena) begin
        if (m_cnt == m_div) begin
          m_cnt = 0; m_phase = ~m_phase; m_tick = 1;
        end else begin
          m_cnt = m_cnt + 1; m_tick = 0;
        end
      end else begin
        m_tick = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; din = 8'h00; ena = 1; cfg_we = 0;
    repeat (2) begin
      step();
      checks++;
      if (dout !== 8'h00 || tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold dout=%h tick=%b required dout=00 tick=0", dout, tick);
      end
    end
    rst = 0;
    repeat (3) begin
      step();
      checks++;
      if (dout !== m_dout || tick !== m_tick) begin
        errors++;
        $display("[TB] FAIL reset_release dout=%h tick=%b required %h %b", dout, tick, m_dout, m_tick);
      end
    end
    checks++;
    if (dout !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL reset_default dout=%h required 0f", dout);
    end
  endtask

  task automatic test_default_inv();
    logic [WIDTH-1:0] pats [2] = '{8'hA5, 8'hFF};
    logic [WIDTH-1:0] want [2] = '{8'hAA, 8'hF0};
    for (int p = 0; p < 2; p++) begin
      din = pats[p];
      repeat (3) begin
        step();
        checks++;
        if (dout !== m_dout || tick !== m_tick) begin
          errors++;
          $display("[TB] FAIL default_inv dout=%h tick=%b required %h %b", dout, tick, m_dout, m_tick);
        end
      end
      checks++;
      if (dout !== want[p]) begin
        errors++;
        $display("[TB] FAIL default_latency din=%h dout=%h required %h", pats[p], dout, want[p]);
      end
    end
  endtask

  task automatic test_blink();
    int ticks = 0;
    int flips = 0;
    logic [WIDTH-1:0] last;
    din = 8'h00;
    repeat (3) step();
    cfg_we = 1; cfg_mode = 2'd2; cfg_mask = 8'hFF; cfg_div = 8'd3;
    step();
    cfg_we = 0;
    last = dout;
    repeat (16) begin
      step();
      checks++;
      if (dout !== m_dout || tick !== m_tick) begin
        errors++;
        $display("[TB] FAIL blink dout=%h tick=%b required %h %b", dout, tick, m_dout, m_tick);
      end
      if (tick === 1'b1) ticks++;
      if (dout !== last) flips++;
      last = dout;
    end
    checks++;
    if (ticks != 4 || flips != 4) begin
      errors++;
      $display("[TB] FAIL blink_rate ticks=%0d flips=%0d required 4 4", ticks, flips);
    end
  endtask

  task automatic test_toggle();
    din = {7'h55, 1'b0};
    repeat (4) step();
    cfg_we = 1; cfg_mode = 2'd3; cfg_mask = 8'h01; cfg_div = 8'd3;
    step();
    cfg_we = 0;
    repeat (3) begin
      din = {7'h55, 1'b1};
      repeat (2) begin
        step();
        checks++;
        if (dout !== m_dout) begin
          errors++;
          $display("[TB] FAIL toggle dout=%h required %h", dout, m_dout);
        end
      end
      din = {7'h55, 1'b0};
      repeat (3) begin
        step();
        checks++;
        if (dout !== m_dout) begin
          errors++;
          $display("[TB] FAIL toggle dout=%h required %h", dout, m_dout);
        end
      end
    end
    repeat (3) step();
    checks++;
    if (dout !== {7'h55, 1'b1}) begin
      errors++;
      $display("[TB] FAIL toggle_final dout=%h required ab", dout);
    end
  endtask

  task automatic test_ena_freeze();
    logic [WIDTH-1:0] held;
    cfg_we = 1; cfg_mode = 2'd2; cfg_mask = 8'hFF; cfg_div = 8'd3;
    din = 8'h3C;
    step();
    cfg_we = 0;
    repeat (6) step();
    ena = 0;
    step();
    held = dout;
    repeat (10) begin
      step();
      checks++;
      if (dout !== held || tick !== 1'b0 || dout !== m_dout) begin
        errors++;
        $display("[TB] FAIL ena_freeze dout=%h tick=%b required %h 0", dout, tick, held);
      end
    end
    ena = 1;
    repeat (12) begin
      step();
      checks++;
      if (dout !== m_dout || tick !== m_tick) begin
        errors++;
        $display("[TB] FAIL ena_resume dout=%h tick=%b required %h %b", dout, tick, m_dout, m_tick);
      end
    end
  endtask

  task automatic test_cfg_on_wrap();
    int guard = 0;
    int wait_cnt = 0;
    while (m_cnt != m_div && guard < 10) begin
      step();
      guard++;
    end
    cfg_we = 1; cfg_mode = 2'd2; cfg_mask = 8'hFF; cfg_div = 8'd3;
    step();
    cfg_we = 0;
    checks++;
    if (tick !== 1'b0 || dout !== m_dout) begin
      errors++;
      $display("[TB] FAIL cfg_on_wrap tick=%b dout=%h required 0 %h", tick, dout, m_dout);
    end
    while (tick !== 1'b1 && wait_cnt < 8) begin
      step();
      wait_cnt++;
    end
    checks++;
    if (wait_cnt != 4) begin
      errors++;
      $display("[TB] FAIL cfg_wrap_restart cycles_to_tick=%0d required 4", wait_cnt);
    end
  endtask

  task automatic test_reset_with_cfg();
    cfg_we = 1; cfg_mode = 2'd3; cfg_mask = 8'hF0; cfg_div = 8'd1;
    step();
    cfg_we = 0;
    din = 8'hF0;
    repeat (4) step();
    rst = 1; cfg_we = 1; ena = 1; cfg_mode = 2'd2; cfg_mask = 8'hFF; cfg_div = 8'd0;
    step();
    checks++;
    if (dout !== 8'h00 || tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_over_cfg dout=%h tick=%b required 00 0", dout, tick);
    end
    rst = 0; cfg_we = 0; din = 8'h33;
    repeat (3) begin
      step();
      checks++;
      if (dout !== m_dout || tick !== m_tick) begin
        errors++;
        $display("[TB] FAIL reset_over_cfg_run dout=%h tick=%b required %h %b", dout, tick, m_dout, m_tick);
      end
    end
    checks++;
    if (dout !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL reset_over_cfg_default dout=%h required 3c", dout);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      din      = WIDTH'($urandom);
      ena      = ($urandom_range(0, 9) != 0);
      cfg_we   = ($urandom_range(0, 24) == 0);
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_mask = WIDTH'($urandom);
      cfg_div  = DIV_W'($urandom_range(0, 4));
      step();
      checks++;
      if (dout !== m_dout || tick !== m_tick) begin
        errors++;
        $display("[TB] FAIL random n=%0d dout=%h tick=%b required %h %b", n, dout, tick, m_dout, m_tick);
      end
    end
    cfg_we = 0; ena = 1;
  endtask

  initial begin
    $display("[TB] starting chan_invert_ctrl bench");
    @(negedge clk);
    test_reset();
    test_default_inv();
    test_blink();
    test_toggle();
    test_ena_freeze();
    test_cfg_on_wrap();
    test_reset_with_cfg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
